fetch_inst_queue: RTL and testbench



---
 rtl/fetch_inst_queue.sv | 82 ++++++++
 tb/tb_fetch_inst_queue.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/fetch_inst_queue.sv
// rtl/fetch_inst_queue.sv - fetch-to-issue instruction queue, 4-wide push, 2-wide pop
// Circular buffer feeding the issue skid buffer; outputs depend on registered state only.
module fetch_inst_queue #(
  parameter int  DATA_WIDTH = 32,
  parameter int  DEPTH      = 8,
  parameter type dtype      = logic [DATA_WIDTH-1:0]
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush_i,
  input  logic [3:0]              push_valid_i,
  input  logic [4*DATA_WIDTH-1:0] push_data_i,
  output logic                    push_ready_o,
  output logic [1:0]              deq_valid_o,
  output logic [2*DATA_WIDTH-1:0] deq_data_o,
  input  logic [1:0]              deq_num_i
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  dtype          mem_q [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [2:0]    push_n;
  logic [1:0]    deq_avail;

  assign push_ready_o = (count_q <= CW'(DEPTH - 4));
  assign deq_valid_o  = {(count_q >= CW'(2)), (count_q >= CW'(1))};
  assign deq_data_o   = {mem_q[head_q + PW'(1)], mem_q[head_q]};
  assign deq_avail    = {1'b0, deq_valid_o[0]} + {1'b0, deq_valid_o[1]};

  always_comb begin
    push_n  = 3'd0;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push_ready_o) begin
      push_n = 3'(push_valid_i[0]) + 3'(push_valid_i[1])
             + 3'(push_valid_i[2]) + 3'(push_valid_i[3]);
    end
    // Ready is judged on the pre-pop count, so a full push always fits.
    head_d  = head_q + PW'(deq_num_i);
    tail_d  = tail_q + PW'(push_n);
    count_d = count_q + CW'(push_n) - CW'(deq_num_i);
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!flush_i) begin
      for (int k = 0; k < 4; k++) begin
        if (3'(k) < push_n) begin
          mem_q[tail_q + PW'(k)] <= push_data_i[k*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  a_pop_le_avail: assert property (@(posedge clk) disable iff (!rst_n)
    deq_num_i <= deq_avail);

  a_push_thermo: assert property (@(posedge clk) disable iff (!rst_n)
    push_valid_i inside {4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111});

endmodule

// File: tb/tb_fetch_inst_queue.sv
// tb/tb_fetch_inst_queue.sv - directed self-checking bench for fetch_inst_queue
module tb_fetch_inst_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush_i;
  logic [3:0]  push_valid_i;
  logic [127:0] push_data_i;
  logic        push_ready_o;
  logic [1:0]  deq_valid_o;
  logic [63:0] deq_data_o;
  logic [1:0]  deq_num_i;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fetch_inst_queue #(.DATA_WIDTH(32), .DEPTH(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush_i      (flush_i),
    .push_valid_i (push_valid_i),
    .push_data_i  (push_data_i),
    .push_ready_o (push_ready_o),
    .deq_valid_o  (deq_valid_o),
    .deq_data_o   (deq_data_o),
    .deq_num_i    (deq_num_i)
  );

  wire [31:0] d0 = deq_data_o[31:0];
  wire [31:0] d1 = deq_data_o[63:32];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic [3:0] pv, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] c, input logic [31:0] d,
                        input logic [1:0] dn, input logic fl);
    push_valid_i = pv;
    push_data_i  = {d, c, b, a};
    deq_num_i    = dn;
    flush_i      = fl;
  endtask

  task automatic go(input logic [3:0] pv, input logic [31:0] a, input logic [31:0] b,
                    input logic [31:0] c, input logic [31:0] d,
                    input logic [1:0] dn, input logic fl);
    set_in(pv, a, b, c, d, dn, fl);
    @(posedge clk);
    #1;
    set_in(4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 2'd0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    set_in(4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 2'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_valid", deq_valid_o, 2'b00);
    check_eq("rst_ready", push_ready_o, 1'b1);
    rst_n = 1'b1;
    go(4'b0000, 0, 0, 0, 0, 2'd0, 1'b0);
    go(4'b0000, 0, 0, 0, 0, 2'd0, 1'b0);
    check_eq("idle_valid", deq_valid_o, 2'b00);
    check_eq("idle_ready", push_ready_o, 1'b1);

    // Basic push of four, then pop 2 and 1; no bypass during the push cycle.
    set_in(4'b1111, 32'hA, 32'hB, 32'hC, 32'hD, 2'd0, 1'b0);
    #1;
    check_eq("nobypass_valid", deq_valid_o, 2'b00);
    @(posedge clk);
    #1;
    set_in(4'b0000, 0, 0, 0, 0, 2'd0, 1'b0);
    check_eq("c1_valid", deq_valid_o, 2'b11);
    check_eq("c1_d0", d0, 32'hA);
    check_eq("c1_d1", d1, 32'hB);
    go(4'b0000, 0, 0, 0, 0, 2'd2, 1'b0);
    check_eq("c2_valid", deq_valid_o, 2'b11);
    check_eq("c2_d0", d0, 32'hC);
    check_eq("c2_d1", d1, 32'hD);
    go(4'b0000, 0, 0, 0, 0, 2'd1, 1'b0);
    check_eq("c3_valid", deq_valid_o, 2'b01);
    check_eq("c3_d0", d0, 32'hD);
    go(4'b0000, 0, 0, 0, 0, 2'd1, 1'b0);
    check_eq("drain_valid", deq_valid_o, 2'b00);

    // Fill to DEPTH, ignored push while full, drain two per cycle.
    go(4'b1111, 32'hE0, 32'hE1, 32'hE2, 32'hE3, 2'd0, 1'b0);
    check_eq("half_ready", push_ready_o, 1'b1);
    go(4'b1111, 32'hF0, 32'hF1, 32'hF2, 32'hF3, 2'd0, 1'b0);
    check_eq("full_ready", push_ready_o, 1'b0);
    check_eq("full_d0", d0, 32'hE0);
    go(4'b1111, 32'h90, 32'h91, 32'h92, 32'h93, 2'd0, 1'b0);
    check_eq("held_ready", push_ready_o, 1'b0);
    check_eq("held_d0", d0, 32'hE0);
    check_eq("held_d1", d1, 32'hE1);
    go(4'b0000, 0, 0, 0, 0, 2'd2, 1'b0);
    check_eq("cnt6_ready", push_ready_o, 1'b0);
    check_eq("cnt6_d0", d0, 32'hE2);
    go(4'b0000, 0, 0, 0, 0, 2'd2, 1'b0);
    check_eq("cnt4_ready", push_ready_o, 1'b1);
    check_eq("cnt4_d0", d0, 32'hF0);
    go(4'b0000, 0, 0, 0, 0, 2'd2, 1'b0);
    check_eq("cnt2_d0", d0, 32'hF2);
    check_eq("cnt2_d1", d1, 32'hF3);
    go(4'b0000, 0, 0, 0, 0, 2'd2, 1'b0);
    check_eq("cnt0_valid", deq_valid_o, 2'b00);

    // Wrap-around: head=tail=4 here; move both to 6, then fill 6,7,0.
    go(4'b0011, 32'h50, 32'h51, 0, 0, 2'd0, 1'b0);
    go(4'b0000, 0, 0, 0, 0, 2'd2, 1'b0);
    go(4'b0111, 32'h66, 32'h77, 32'h00, 0, 2'd0, 1'b0);
    check_eq("wrap_d0", d0, 32'h66);
    check_eq("wrap_d1", d1, 32'h77);
    go(4'b0000, 0, 0, 0, 0, 2'd1, 1'b0);
    check_eq("wrap_pop_d0", d0, 32'h77);
    check_eq("wrap_pop_d1", d1, 32'h00);
    go(4'b0111, 32'h11, 32'h22, 32'h33, 0, 2'd0, 1'b0);
    check_eq("wrap_push_d0", d0, 32'h77);
    go(4'b0000, 0, 0, 0, 0, 2'd2, 1'b0);
    check_eq("tail1_d0", d0, 32'h11);
    check_eq("tail1_d1", d1, 32'h22);
    go(4'b0000, 0, 0, 0, 0, 2'd2, 1'b0);
    check_eq("one_valid", deq_valid_o, 2'b01);
    check_eq("one_d0", d0, 32'h33);

    // count=1: push three and pop one together -> count=3.
    go(4'b0111, 32'hC0, 32'hC1, 32'hC2, 0, 2'd1, 1'b0);
    check_eq("simul_valid", deq_valid_o, 2'b11);
    check_eq("simul_d0", d0, 32'hC0);
    check_eq("simul_d1", d1, 32'hC1);
    go(4'b0011, 32'hD0, 32'hD1, 0, 0, 2'd0, 1'b0);
    check_eq("cnt5_ready", push_ready_o, 1'b0);

    // Flush overrides push and pop.
    go(4'b1111, 32'h1, 32'h2, 32'h3, 32'h4, 2'd2, 1'b1);
    check_eq("flush_valid", deq_valid_o, 2'b00);
    check_eq("flush_ready", push_ready_o, 1'b1);
    go(4'b1111, 32'h5, 32'h6, 32'h7, 32'h8, 2'd0, 1'b1);
    check_eq("flush_push_valid", deq_valid_o, 2'b00);

    // Asynchronous reset mid-stream.
    go(4'b1111, 32'hAA, 32'hBB, 32'hCC, 32'hDD, 2'd0, 1'b0);
    check_eq("pre_rst_valid", deq_valid_o, 2'b11);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_valid", deq_valid_o, 2'b00);
    check_eq("async_rst_ready", push_ready_o, 1'b1);
    #3;
    rst_n = 1'b1;
    go(4'b0000, 0, 0, 0, 0, 2'd0, 1'b0);
    check_eq("post_rst_valid", deq_valid_o, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
